// File: rtl/cube_uart_tx_pkg.sv
// Shared definitions for the lightcube UART transmit path: FSM states and bit-time divider.
package cube_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned DATA_BITS = 8;

    // Rounded clocks per line bit; the receiver uses the same rounding so both ends agree.
    function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/cube_uart_tx_sync_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers and a registered first-word output.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [PW-1:0]    cur_count;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic [AW-1:0]    rd_nxt_idx;
    logic             full, do_push, do_pop;

    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign cur_count  = wr_ptr_q - rd_ptr_q;
    assign rd_nxt_idx = rd_ptr_q[AW-1:0] + AW'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = wr_ptr_d - rd_ptr_d;
        ready_d  = (count_d != PW'(DEPTH));
        rdata_d  = rdata_q;
        // Head word: the incoming byte when it becomes the only entry, else the next stored word.
        if (do_push && (empty || (do_pop && cur_count == PW'(1)))) begin
            rdata_d = wdata;
        end else if (do_pop) begin
            rdata_d = mem_q[rd_nxt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign count = count_q;

endmodule

// File: rtl/cube_uart_tx.sv
// 8N1 UART transmitter for the lightcube host link: byte FIFO feeding a serializer FSM.
module cube_uart_tx
    import cube_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 fifo_push, fifo_pop, fifo_empty, fifo_ready;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic [CW-1:0]        fifo_cnt;
    logic                 bit_end;

    assign fifo_push = tx_valid && fifo_ready;
    assign bit_end   = (baud_q == BAUD_W'(DIV - 1));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .ready (fifo_ready),
        .count (fifo_cnt)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? '0 : baud_q + BAUD_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Back-to-back frames: reload straight into the next start bit.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE) || (fifo_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_ready   = fifo_ready;
    assign fifo_count = fifo_cnt;

endmodule
